fetch_issue_ctrl: RTL and testbench
===================================

Name: fetch_issue_ctrl

Overview:
- Program-counter and instruction-issue stage that consumes the stall and stall_pm signals from the stall block.
- It drives the current opcode back to the stall block, holds the PC, and inserts NOP bubbles or replays the held instruction as commanded.
- It also applies taken-branch redirects.
- It sits between program memory (combinational read at pc) and the decode stage.

Parameters:
- ADDR_W, 32, width of pc and branch_target.
- RESET_PC, 0, pc value loaded on reset.
- NOP, 32'h00000000, instruction word inserted as a bubble.
- CNT_W, 16, width of the saturating stall and bubble statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- instr_in  input  [0:31]  program memory word at the current pc (combinational, same cycle).
- stall  input  1  from stall block: hold pc, issue a NOP bubble.
- stall_pm  input  1  from stall block: hold pc, replay the held instruction.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  [ADDR_W-1:0]  redirect address.
- pc  output  [ADDR_W-1:0]  program memory address.
- instr_out  output  [0:31]  instruction register to decode.
- op  output  [0:5]  equals instr_out[0:5]; feeds the stall block op input.
- valid  output  1  1 when instr_out is a real fetched instruction, 0 for a bubble.
- stall_cycles  output  [CNT_W-1:0]  count of cycles with stall or stall_pm high; saturating.
- bubble_count  output  [CNT_W-1:0]  count of NOPs inserted by stall or branch flush; saturating.

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled on the edge only.
- Reset values: pc=RESET_PC, instr_out=NOP, op=0, valid=0, stall_cycles=0, bubble_count=0.
- Reset overrides every other input. Reset asserted mid-stall or mid-branch discards the pending action; the first fetch after reset deassertion is from RESET_PC.
- Priority per cycle is branch_taken > stall > stall_pm > normal.
- Normal (no control input high):
  - pc <= pc+4, modulo 2^ADDR_W; 32'hFFFFFFFC wraps to 0.
  - instr_out <= instr_in, valid <= 1.
- branch_taken=1:
  - pc <= {branch_target[ADDR_W-1:2], 2'b00}; low bits are forced to zero.
  - instr_out <= NOP, valid <= 0, bubble_count += 1.
  - stall and stall_pm are ignored that cycle, but stall_cycles still counts them.
- stall=1 (no branch):
  - pc holds, instr_out <= NOP, valid <= 0, bubble_count += 1.
  - Any stall_pm value is ignored.
- stall_pm=1 only: pc holds; instr_out, op and valid hold (replay); bubble_count unchanged.
- stall_cycles increments on any cycle where stall | stall_pm is high, including branch cycles.
- Both counters saturate at all ones and never wrap.
- Issue latency: the instruction at address A appears on instr_out one cycle after pc==A with no stall or branch high.
- Consecutive stall cycles produce consecutive bubbles with pc frozen. On the first cycle after stall deasserts, the instruction at the held pc issues.
- op is a registered copy of instr_out[0:5], so it returns 0 during bubbles. A stall raised on an op therefore does not re-trigger from its own bubble.
- There is no combinational path from stall or stall_pm to any output.

Test Plan:
- Reset then free run:
  - Stimulus: reset=1 for 2 cycles, then memory returns addr-as-data for 4 cycles.
  - Response: pc sequence 0,4,8,12,16; instr_out 0,4,8,12; valid=1 from cycle 2; counters 0.
- Single stall:
  - Stimulus: at pc=8, stall=1 for 2 cycles (op 6'b010100 issued at instr 4).
  - Response: pc holds 8 for 2 cycles; instr_out=NOP and valid=0 twice; next issue is word 8; bubble_count=2, stall_cycles=2.
- Replay:
  - Stimulus: stall_pm=1 for 3 cycles while instr_out=32'h78000010 (op 6'b011110).
  - Response: instr_out, op and valid hold all 3 cycles; pc holds; stall_cycles=3, bubble_count=0.
- Branch beats stall:
  - Stimulus: branch_taken=1, branch_target=32'h00000103, stall=1, same cycle.
  - Response: pc=32'h00000100, instr_out=NOP, valid=0; bubble_count +1, stall_cycles +1.
- Wrap and saturation:
  - Stimulus: RESET_PC=32'hFFFFFFFC with CNT_W=2, then stall held for 5 cycles.
  - Response: after one normal cycle pc=0; with the stall, both counters saturate at 3 with no wrap.
- Reset mid-stall:
  - Stimulus: stall=1, pc=12, reset=1 for one cycle.
  - Response: pc=RESET_PC, instr_out=NOP, valid=0, counters 0; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_issue_ctrl_if.sv
// rtl/fetch_issue_ctrl_if.sv - fetch/issue stage bus: program memory, stall block, branch and decode signals
interface fetch_issue_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [0:31]       instr_in;
  logic              stall;
  logic              stall_pm;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;
  logic [0:31]       instr_out;
  logic [0:5]        op;
  logic              valid;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  bubble_count;

  // Environment side: memory, stall block and execute drive the controls.
  modport master (
    output instr_in, stall, stall_pm, branch_taken, branch_target,
    input  pc, instr_out, op, valid, stall_cycles, bubble_count
  );

  // Fetch/issue stage side.
  modport slave (
    input  instr_in, stall, stall_pm, branch_taken, branch_target,
    output pc, instr_out, op, valid, stall_cycles, bubble_count
  );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// rtl/fetch_issue_ctrl.sv - pc register and instruction issue with bubble, replay and branch redirect
module fetch_issue_ctrl #(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [0:31]      NOP      = 32'h00000000,
  parameter int               CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  fetch_issue_ctrl_if.slave bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [0:31]       instr_q, instr_d;
  logic [0:5]        op_q, op_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              bubble;

  // Next-state selection: branch beats stall beats replay beats normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    op_d    = op_q;
    valid_d = valid_q;
    bubble  = 1'b0;
    if (bus.branch_taken) begin
      pc_d    = {bus.branch_target[ADDR_W-1:2], 2'b00};
      instr_d = NOP;
      op_d    = NOP[0:5];
      valid_d = 1'b0;
      bubble  = 1'b1;
    end else if (bus.stall) begin
      instr_d = NOP;
      op_d    = NOP[0:5];
      valid_d = 1'b0;
      bubble  = 1'b1;
    end else if (bus.stall_pm) begin
      // Replay: everything holds, including the issued instruction.
      pc_d = pc_q;
    end else begin
      pc_d    = pc_q + ADDR_W'(4);
      instr_d = bus.instr_in;
      op_d    = bus.instr_in[0:5];
      valid_d = 1'b1;
    end
  end

  // Saturating statistics; stall_cycles counts stall requests even when a branch wins.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((bus.stall || bus.stall_pm) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // State register; reset discards any pending stall or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP;
      op_q         <= '0;
      valid_q      <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      op_q         <= op_d;
      valid_q      <= valid_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.instr_out    = instr_q;
  assign bus.op           = op_q;
  assign bus.valid        = valid_q;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// tb/tb_fetch_issue_ctrl.sv - directed bench for fetch_issue_ctrl
module tb_fetch_issue_ctrl;

  logic clk;
  logic reset;
  logic rst_w;
  logic mem_mode;
  int   checks;
  int   errors;

  fetch_issue_ctrl_if #(.ADDR_W(32), .CNT_W(16)) dif ();
  fetch_issue_ctrl_if #(.ADDR_W(32), .CNT_W(2))  wif ();

  fetch_issue_ctrl #(
    .ADDR_W(32), .RESET_PC(32'h0), .NOP(32'h0), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(dif.slave)
  );

  fetch_issue_ctrl #(
    .ADDR_W(32), .RESET_PC(32'hFFFFFFFC), .NOP(32'h0), .CNT_W(2)
  ) u_wrap (
    .clk(clk), .reset(rst_w), .bus(wif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: address-as-data, with two patched words in mode 1.
  always_comb begin
    dif.instr_in = dif.pc;
    if (mem_mode && dif.pc == 32'd4)  dif.instr_in = 32'h50000004;
    if (mem_mode && dif.pc == 32'd12) dif.instr_in = 32'h78000010;
  end

  always_comb wif.instr_in = wif.pc;

  function automatic logic [102:0] obs();
    return {dif.pc, dif.instr_out, dif.op, dif.valid, dif.stall_cycles, dif.bubble_count};
  endfunction

  function automatic logic [102:0] expv(logic [31:0] pc, logic [31:0] ins, logic v,
                                        logic [15:0] sc, logic [15:0] bc);
    return {pc, ins, ins[31:26], v, sc, bc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dif.stall = 0; dif.stall_pm = 0; dif.branch_taken = 0; dif.branch_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [102:0] e;
    mem_mode = 0;
    do_reset();
    e = expv(32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_free_run();
    logic [102:0] e;
    for (int i = 1; i <= 4; i++) begin
      step();
      e = expv(32'(4 * i), 32'(4 * (i - 1)), 1'b1, 16'd0, 16'd0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL free_run%0d got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_single_stall();
    logic [102:0] e;
    mem_mode = 1;
    do_reset();
    step(); step();
    e = expv(32'd8, 32'h50000004, 1'b1, 16'd0, 16'd0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL stall_pre got %h exp %h", obs(), e);
    end
    dif.stall = 1;
    for (int i = 1; i <= 2; i++) begin
      step();
      e = expv(32'd8, 32'h0, 1'b0, 16'(i), 16'(i));
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL stall_bubble%0d got %h exp %h", i, obs(), e);
      end
    end
    dif.stall = 0;
    step();
    e = expv(32'd12, 32'd8, 1'b1, 16'd2, 16'd2);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL stall_resume got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_replay();
    logic [102:0] e;
    step();
    e = expv(32'd16, 32'h78000010, 1'b1, 16'd2, 16'd2);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL replay_pre got %h exp %h", obs(), e);
    end
    dif.stall_pm = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      e = expv(32'd16, 32'h78000010, 1'b1, 16'(2 + i), 16'd2);
      checks++;
      if (obs() !== e || dif.op !== 6'b011110) begin
        errors++; $display("FAIL replay%0d got %h exp %h", i, obs(), e);
      end
    end
    dif.stall_pm = 0;
    step();
    e = expv(32'd20, 32'd16, 1'b1, 16'd5, 16'd2);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL replay_resume got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_branch_priority();
    logic [102:0] e;
    logic [31:0]  tgt   [6] = '{32'h103, 32'h0,   32'h41, 32'h0,  32'h0,  32'h0};
    logic [3:0]   ctl   [6] = '{4'b1010, 4'b0000, 4'b1000, 4'b0000, 4'b0011, 4'b0000};
    logic [31:0]  e_pc  [6] = '{32'h100, 32'h104, 32'h40, 32'h44, 32'h44, 32'h48};
    logic [31:0]  e_ins [6] = '{32'h0,   32'h100, 32'h0,  32'h40, 32'h0,  32'h44};
    logic         e_v   [6] = '{1'b0,    1'b1,    1'b0,   1'b1,   1'b0,   1'b1};
    logic [15:0]  e_sc  [6] = '{16'd6,   16'd6,   16'd6,  16'd6,  16'd7,  16'd7};
    logic [15:0]  e_bc  [6] = '{16'd3,   16'd3,   16'd4,  16'd4,  16'd5,  16'd5};
    for (int i = 0; i < 6; i++) begin
      dif.branch_taken  = ctl[i][3];
      dif.stall         = ctl[i][1];
      dif.stall_pm      = ctl[i][0];
      dif.branch_target = tgt[i];
      step();
      e = expv(e_pc[i], e_ins[i], e_v[i], e_sc[i], e_bc[i]);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL branch_prio%0d got %h exp %h", i, obs(), e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_action();
    logic [102:0] e;
    do_reset();
    step(); step(); step();
    dif.stall = 1; reset = 1;
    step();
    e = expv(32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_mid_stall got %h exp %h", obs(), e);
    end
    dif.stall = 0; dif.branch_taken = 1; dif.branch_target = 32'h200;
    step();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_mid_branch got %h exp %h", obs(), e);
    end
    idle_inputs(); reset = 0;
    step();
    e = expv(32'd4, 32'h0, 1'b1, 16'd0, 16'd0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_resume0 got %h exp %h", obs(), e);
    end
    step();
    e = expv(32'd8, 32'h50000004, 1'b1, 16'd0, 16'd0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_resume1 got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_wrap_saturation();
    logic [68:0] g, e;
    wif.stall = 0; wif.stall_pm = 0; wif.branch_taken = 0; wif.branch_target = '0;
    rst_w = 1;
    step();
    g = {wif.pc, wif.instr_out, wif.valid, wif.stall_cycles, wif.bubble_count};
    e = {32'hFFFFFFFC, 32'h0, 1'b0, 2'd0, 2'd0};
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL wrap_reset got %h exp %h", g, e);
    end
    rst_w = 0;
    step();
    g = {wif.pc, wif.instr_out, wif.valid, wif.stall_cycles, wif.bubble_count};
    e = {32'h0, 32'hFFFFFFFC, 1'b1, 2'd0, 2'd0};
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL wrap_pc got %h exp %h", g, e);
    end
    wif.stall = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      g = {wif.pc, wif.instr_out, wif.valid, wif.stall_cycles, wif.bubble_count};
      e = {32'h0, 32'h0, 1'b0, 2'((i > 3) ? 3 : i), 2'((i > 3) ? 3 : i)};
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL saturate%0d got %h exp %h", i, g, e);
      end
    end
    wif.stall = 0;
    step();
    g = {wif.pc, wif.instr_out, wif.valid, wif.stall_cycles, wif.bubble_count};
    e = {32'h4, 32'h0, 1'b1, 2'd3, 2'd3};
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL saturate_hold got %h exp %h", g, e);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1; rst_w = 1; mem_mode = 0;
    idle_inputs();
    wif.stall = 0; wif.stall_pm = 0; wif.branch_taken = 0; wif.branch_target = '0;
    test_reset();
    test_free_run();
    test_single_stall();
    test_replay();
    test_branch_priority();
    test_reset_mid_action();
    test_wrap_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
